// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 receiver.
//   rx_state_t      : receiver FSM states
//   PARITY_*        : PARITY_MODE encodings (0 none, 1 odd, 2 even)
//   expected_parity : parity bit a transmitter would send for a word
package rs232_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Odd parity: data plus parity bit must contain an odd number of ones.
  // Even parity: an even number. Only the low nbits of word are counted.
  function automatic logic expected_parity(input logic [8:0]  word,
                                           input int unsigned nbits,
                                           input int unsigned mode);
    logic x;
    x = 1'b0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (i < nbits) x = x ^ word[i];
    end
    return (mode == PARITY_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/rs232_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus falling-edge detect.
// All flops reset to 1 (line idle) so reset release never looks like a start.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   rx   : raw serial line
//   rx_s : synchronised line level
//   fall : one-cycle pulse when rx_s goes 1 -> 0
module rs232_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rx;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rx_s = sync;
  assign fall = prev & ~sync;

endmodule

// File: rtl/rs232_receiver_param.sv
// Parametrised RS-232 receiver: rx line -> parallel words on a valid/ready
// handshake with per-word frame/parity status and an overrun pulse.
// Optional build macro RS232_RX_MAJORITY_EN: 2-of-3 majority sampling around
// the bit centre (decision one cycle later); undefined = single centre sample.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   rx         : serial line, idles high
//   data       : received word, stable while data_valid
//   data_valid : word available
//   data_ready : consumer accepts word when data_valid && data_ready
//   frame_err  : a stop bit was sampled low (qualified by data_valid)
//   parity_err : parity mismatch (qualified by data_valid)
//   overrun    : one-cycle pulse when a completed frame is dropped
//   busy       : FSM not idle
module rs232_receiver_param
  import rs232_pkg::*;
#(
  parameter int unsigned CLK_DIVIDER = 5208,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [15:0] TICK_LAST = 16'(CLK_DIVIDER - 1);
`ifdef RS232_RX_MAJORITY_EN
  localparam logic [15:0] TICK_SAMPLE = 16'(CLK_DIVIDER / 2 + 1);
`else
  localparam logic [15:0] TICK_SAMPLE = 16'(CLK_DIVIDER / 2);
`endif
  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_nx;
  logic                 rx_s;
  logic                 rx_fall;
  logic [15:0]          tick;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 fe_acc;
  logic                 bit_val;
  logic                 at_sample;
  logic                 bit_end;
  logic                 frame_done;
  logic                 par_mismatch;
  logic [8:0]           word_pad;

  rs232_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (rx_fall)
  );

`ifdef RS232_RX_MAJORITY_EN
  // hist[1]/hist[0] hold the line at ticks SAMPLE-2 and SAMPLE-1, so at the
  // decision tick the three votes are centre-1, centre, centre+1.
  logic [1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= '1;
    else     hist <= {hist[0], rx_s};
  end

  always_comb begin
    bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
  end
`else
  always_comb begin
    bit_val = rx_s;
  end
`endif

  assign at_sample  = (tick == TICK_SAMPLE);
  assign bit_end    = (tick == TICK_LAST);
  // The last stop bit completes the frame at its sample point, not bit end.
  assign frame_done = (state == S_STOP) && at_sample && (stop_cnt == STOP_LAST);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (rx_fall) state_nx = S_START;
      S_START: begin
        if (at_sample && bit_val) state_nx = S_IDLE;   // false start
        else if (bit_end)         state_nx = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_cnt == BIT_LAST))
          state_nx = (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (bit_end) state_nx = S_STOP;
      S_STOP:   if (frame_done) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Bit timer and per-frame datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      fe_acc   <= 1'b0;
    end else begin
      if ((state_nx != state) || bit_end) tick <= '0;
      else                                 tick <= tick + 16'd1;

      case (state)
        S_IDLE: begin
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          fe_acc   <= 1'b0;
        end
        S_DATA: begin
          if (at_sample) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          if (bit_end)   bit_cnt <= bit_cnt + 4'd1;
        end
        S_PARITY: begin
          if (at_sample) par_bit <= bit_val;
        end
        S_STOP: begin
          if (at_sample && !bit_val) fe_acc <= 1'b1;
          if (bit_end)               stop_cnt <= stop_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    word_pad                = '0;
    word_pad[DATA_BITS-1:0] = shreg;
    par_mismatch = (PARITY_MODE != PARITY_NONE) &&
                   (par_bit != expected_parity(word_pad, DATA_BITS, PARITY_MODE));
  end

  // Output holding register and handshake. The last stop sample is folded
  // directly into frame_err because fe_acc only catches it one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done && (!data_valid || data_ready)) begin
        data       <= shreg;
        data_valid <= 1'b1;
        frame_err  <= fe_acc | ~bit_val;
        parity_err <= par_mismatch;
      end else begin
        if (data_valid && data_ready) data_valid <= 1'b0;
        if (frame_done)               overrun    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rs232_receiver_param.sv
// Bench for rs232_receiver_param: one 8N1 instance and one 8E2 instance,
// directed plus random frames checked against a frame-level reference model.
module tb_rs232_receiver_param;

  localparam int unsigned DIV = 16;

  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [7:0] d;
  } word_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_n = 1'b1, rdy_n = 1'b1;
  logic       rx_e = 1'b1, rdy_e = 1'b1;
  logic [7:0] data_n, data_e;
  logic       dv_n, fe_n, pe_n, ov_n, busy_n;
  logic       dv_e, fe_e, pe_e, ov_e, busy_e;

  int checks   = 0;
  int failures = 0;
  int dvcyc_n  = 0;
  int ov_cnt_n = 0;
  int ov_cnt_e = 0;

  word_t cap_n[$], cap_e[$], exp_n[$], exp_e[$];

  always #5 clk = ~clk;

  rs232_receiver_param #(.CLK_DIVIDER(DIV), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_n (
    .clk(clk), .rst(rst), .rx(rx_n), .data(data_n), .data_valid(dv_n), .data_ready(rdy_n),
    .frame_err(fe_n), .parity_err(pe_n), .overrun(ov_n), .busy(busy_n)
  );

  rs232_receiver_param #(.CLK_DIVIDER(DIV), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)) u_e (
    .clk(clk), .rst(rst), .rx(rx_e), .data(data_e), .data_valid(dv_e), .data_ready(rdy_e),
    .frame_err(fe_e), .parity_err(pe_e), .overrun(ov_e), .busy(busy_e)
  );

  // Monitor: record every accepted word and count valid/overrun cycles.
  always @(negedge clk) begin
    if (dv_n && rdy_n) cap_n.push_back('{fe: fe_n, pe: pe_n, d: data_n});
    if (dv_e && rdy_e) cap_e.push_back('{fe: fe_e, pe: pe_e, d: data_e});
    if (dv_n) dvcyc_n++;
    if (ov_n) ov_cnt_n++;
    if (ov_e) ov_cnt_e++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_bit(input int which, input logic v);
    for (int i = 0; i < int'(DIV); i++) begin
      @(posedge clk); #2;
      if (which == 0) rx_n = v; else rx_e = v;
    end
  endtask

  task automatic idle(input int which, input int nbits);
    for (int i = 0; i < nbits; i++) drive_bit(which, 1'b1);
  endtask

  // Instance 0 is 8N1 (s1, pbit ignored); instance 1 is 8E2.
  task automatic send_frame(input int which, input logic [7:0] d, input logic pbit,
                            input logic s0, input logic s1);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (which == 1) drive_bit(which, pbit);
    drive_bit(which, s0);
    if (which == 1) drive_bit(which, s1);
  endtask

  // Reference model: what the receiver must report for a frame as sent.
  task automatic expect_frame(input int which, input logic [7:0] d, input logic pbit,
                              input logic s0, input logic s1);
    word_t w;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    w.d = d;
    if (which == 0) begin
      w.fe = !s0;
      w.pe = 1'b0;
      exp_n.push_back(w);
    end else begin
      w.fe = !(s0 && s1);
      w.pe = ((ones + int'(pbit)) % 2) != 0;   // even parity: total ones must be even
      exp_e.push_back(w);
    end
  endtask

  task automatic compare_q(input int which, input string tag);
    word_t w, e;
    if (which == 0) begin
      check({tag, " count"}, 32'(cap_n.size()), 32'(exp_n.size()));
      while (cap_n.size() != 0 && exp_n.size() != 0) begin
        w = cap_n.pop_front(); e = exp_n.pop_front();
        check({tag, " data"}, 32'(w.d), 32'(e.d));
        check({tag, " frame_err"}, 32'(w.fe), 32'(e.fe));
        check({tag, " parity_err"}, 32'(w.pe), 32'(e.pe));
      end
      cap_n.delete(); exp_n.delete();
    end else begin
      check({tag, " count"}, 32'(cap_e.size()), 32'(exp_e.size()));
      while (cap_e.size() != 0 && exp_e.size() != 0) begin
        w = cap_e.pop_front(); e = exp_e.pop_front();
        check({tag, " data"}, 32'(w.d), 32'(e.d));
        check({tag, " frame_err"}, 32'(w.fe), 32'(e.fe));
        check({tag, " parity_err"}, 32'(w.pe), 32'(e.pe));
      end
      cap_e.delete(); exp_e.delete();
    end
  endtask

  initial begin : stim
    logic [7:0] d;
    logic       p, s0, s1;
    int         base, cnt;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset data", 32'(data_n), 32'h0);
    check("reset data_valid", 32'(dv_n), 32'h0);
    check("reset busy", 32'(busy_n), 32'h0);
    check("reset flags", 32'({fe_n, pe_n, ov_n}), 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    idle(0, 2);
    check("post-reset data_valid", 32'(dv_n), 32'h0);

    // 8N1 0x55, single-cycle valid with ready high
    base = dvcyc_n;
    expect_frame(0, 8'h55, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1);
    idle(0, 1);
    check("0x55 valid cycles", 32'(dvcyc_n - base), 32'd1);
    compare_q(0, "8N1 0x55");

    // Random 8N1 frames, occasional bad stop bit
    for (int k = 0; k < 12; k++) begin
      d  = 8'($urandom);
      s0 = ($urandom_range(0, 3) != 0);
      expect_frame(0, d, 1'b0, s0, 1'b1);
      send_frame(0, d, 1'b0, s0, 1'b1);
      idle(0, 1);
      compare_q(0, "8N1 random");
    end

    // 8E2: 0xA3 has four ones, so a parity bit of 1 is wrong
    expect_frame(1, 8'hA3, 1'b1, 1'b1, 1'b1);
    send_frame(1, 8'hA3, 1'b1, 1'b1, 1'b1);
    idle(1, 1);
    compare_q(1, "8E2 0xA3 bad parity");
    expect_frame(1, 8'hA3, 1'b0, 1'b1, 1'b1);
    send_frame(1, 8'hA3, 1'b0, 1'b1, 1'b1);
    idle(1, 1);
    compare_q(1, "8E2 0xA3 good parity");

    // Random 8E2 frames: random parity bit and stop bits
    for (int k = 0; k < 12; k++) begin
      d  = 8'($urandom);
      p  = 1'($urandom_range(0, 1));
      s0 = ($urandom_range(0, 3) != 0);
      s1 = ($urandom_range(0, 3) != 0);
      expect_frame(1, d, p, s0, s1);
      send_frame(1, d, p, s0, s1);
      idle(1, 1);
      compare_q(1, "8E2 random");
    end

    // Stop bit low leading into a 40-bit break, then 0x11
    expect_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) drive_bit(0, 1'b0);
    idle(0, 2);
    expect_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
    idle(0, 1);
    compare_q(0, "break");

    // 5-cycle glitch: false start, nothing delivered
    base = dvcyc_n;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2 rx_n = 1'b0;
    end
    @(posedge clk); #2 rx_n = 1'b1;
    @(negedge clk);
    check("glitch busy rose", 32'(busy_n), 32'h1);
    cnt = 0;
    while (busy_n && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("glitch busy clears early", 32'(cnt < int'(DIV)), 32'h1);
    idle(0, 3);
    check("glitch no valid", 32'(dvcyc_n - base), 32'd0);
    compare_q(0, "glitch");

    // Overrun: ready low, two back-to-back frames
    @(posedge clk); #2 rdy_n = 1'b0;
    base = ov_cnt_n;
    send_frame(0, 8'h01, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h02, 1'b0, 1'b1, 1'b1);
    idle(0, 2);
    @(negedge clk);
    check("overrun held data", 32'(data_n), 32'h01);
    check("overrun held valid", 32'(dv_n), 32'h1);
    check("overrun pulses", 32'(ov_cnt_n - base), 32'd1);
    @(posedge clk); #2 rdy_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("valid drops after accept", 32'(dv_n), 32'h0);
    expect_frame(0, 8'h01, 1'b0, 1'b1, 1'b1);
    compare_q(0, "overrun accept");

    // Reset in the middle of 0xFF's data bits, then 0x42
    drive_bit(0, 1'b0);
    for (int k = 0; k < 4; k++) drive_bit(0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #2 rx_n = 1'b1;
    end
    @(negedge clk);
    check("busy mid-frame", 32'(busy_n), 32'h1);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    check("mid reset data", 32'(data_n), 32'h0);
    check("mid reset valid/busy", 32'({dv_n, busy_n}), 32'h0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    idle(0, 2);
    expect_frame(0, 8'h42, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h42, 1'b0, 1'b1, 1'b1);
    idle(0, 1);
    compare_q(0, "after reset");
    check("8E2 no overrun", 32'(ov_cnt_e), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
